// File: rtl/mvu_job_ctrl.sv
// MVU job controller: sequences CLR -> RUN -> QUANT -> OUT -> DONE for one MVU job.
// Latency: start edge to done pulse is 1 + countdown + 1 + max(oprecision,1) cycles; outputs registered.
// Backpressure: none; start while busy is dropped, abort returns to IDLE on the next edge.
// Optional feature: define MVU_JOB_CTRL_IRQ_EN to add irq_clr input and sticky irq output.
module mvu_job_ctrl #(
  parameter int BCNTDWN = 29,
  parameter int BPREC   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [BCNTDWN-1:0] countdown,
  input  logic [BPREC-1:0]   iprecision,
  input  logic [BPREC-1:0]   wprecision,
  input  logic [BPREC-1:0]   oprecision,
`ifdef MVU_JOB_CTRL_IRQ_EN
  input  logic               irq_clr,
  output logic               irq,
`endif
  output logic               busy,
  output logic               done,
  output logic               acc_clr,
  output logic               acc_sh,
  output logic               max_clr,
  output logic               quant_clr,
  output logic               quant_start
);

  // Block length is always held at 12 bits; 63*63 = 3969 fits without overflow.
  localparam int BBLK = 12;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_QUANT = 3'd3,
    S_OUT   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [BCNTDWN-1:0] cd_q;
  logic [BPREC-1:0]   ip_q, wp_q, op_q;
  logic [BCNTDWN-1:0] cnt_q, cnt_d;   // RUN cycles remaining, including the current one
  logic [BBLK-1:0]    blk_q, blk_d;   // 1-based position of the current RUN cycle in its block
  logic [BPREC-1:0]   ocnt_q, ocnt_d; // OUT cycles remaining, including the current one
  logic [BBLK-1:0]    ip_ext, wp_ext, blk_len;
  logic [BPREC-1:0]   op_eff;
  logic               take_job;

  logic busy_d, done_d, acc_clr_d, acc_sh_d, max_clr_d, quant_clr_d, quant_start_d;

  // A zero precision behaves as a precision of one.
  assign ip_ext   = (ip_q == '0) ? BBLK'(1) : BBLK'(ip_q);
  assign wp_ext   = (wp_q == '0) ? BBLK'(1) : BBLK'(wp_q);
  assign blk_len  = ip_ext * wp_ext;
  assign op_eff   = (op_q == '0) ? BPREC'(1) : op_q;
  assign take_job = (state_q == S_IDLE) && start && !abort;

  // State, counters and the job configuration snapshot taken on the accepting edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
      ocnt_q  <= '0;
      cd_q    <= '0;
      ip_q    <= '0;
      wp_q    <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      ocnt_q  <= ocnt_d;
      if (take_job) begin
        cd_q <= countdown;
        ip_q <= iprecision;
        wp_q <= wprecision;
        op_q <= oprecision;
      end
    end
  end

  // Next state and next counter values; abort overrides every busy state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    ocnt_d  = ocnt_q;
    case (state_q)
      S_IDLE: begin
        if (take_job) state_d = S_CLR;
      end
      S_CLR: begin
        cnt_d   = cd_q;
        blk_d   = BBLK'(1);
        state_d = (cd_q != '0) ? S_RUN : S_QUANT;
      end
      S_RUN: begin
        cnt_d = cnt_q - BCNTDWN'(1);
        blk_d = (blk_q == blk_len) ? BBLK'(1) : blk_q + BBLK'(1);
        if (cnt_q == BCNTDWN'(1)) state_d = S_QUANT;
      end
      S_QUANT: begin
        ocnt_d  = op_eff;
        state_d = S_OUT;
      end
      S_OUT: begin
        ocnt_d = ocnt_q - BPREC'(1);
        if (ocnt_q == BPREC'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // Output values for the state being entered, so the registered strobes line up with it.
  always_comb begin
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    acc_clr_d     = (state_d == S_CLR);
    max_clr_d     = (state_d == S_CLR);
    quant_clr_d   = (state_d == S_CLR);
    quant_start_d = (state_d == S_QUANT);
    acc_sh_d      = (state_d == S_RUN) && (blk_d == blk_len);
  end

  // Registered outputs; no input reaches an output without passing a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      acc_clr     <= 1'b0;
      acc_sh      <= 1'b0;
      max_clr     <= 1'b0;
      quant_clr   <= 1'b0;
      quant_start <= 1'b0;
    end else begin
      busy        <= busy_d;
      done        <= done_d;
      acc_clr     <= acc_clr_d;
      acc_sh      <= acc_sh_d;
      max_clr     <= max_clr_d;
      quant_clr   <= quant_clr_d;
      quant_start <= quant_start_d;
    end
  end

`ifdef MVU_JOB_CTRL_IRQ_EN
  // Sticky completion interrupt; a set on the same edge as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else if (state_d == S_DONE) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_mvu_job_ctrl.sv
// Self-checking bench for mvu_job_ctrl: random jobs against a cycle-indexed job model.
// Cycle k is the value seen between active edge k-1 and edge k, the start edge being edge 0.
// Optional irq checks are compiled when MVU_JOB_CTRL_IRQ_EN is defined.
module tb_mvu_job_ctrl;

  logic        clk, rst_n, start, abort;
  logic [28:0] countdown;
  logic [5:0]  iprecision, wprecision, oprecision;
  logic        busy, done, acc_clr, acc_sh, max_clr, quant_clr, quant_start;
`ifdef MVU_JOB_CTRL_IRQ_EN
  logic        irq_clr, irq;
  logic        irq_obs [0:255];
`endif

  logic [6:0]  outv;
  logic [6:0]  obs [0:255];
  int          total = 0;
  int          bad = 0;
  int          n_done, n_sh;

  mvu_job_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .countdown(countdown), .iprecision(iprecision),
    .wprecision(wprecision), .oprecision(oprecision),
`ifdef MVU_JOB_CTRL_IRQ_EN
    .irq_clr(irq_clr), .irq(irq),
`endif
    .busy(busy), .done(done), .acc_clr(acc_clr), .acc_sh(acc_sh),
    .max_clr(max_clr), .quant_clr(quant_clr), .quant_start(quant_start)
  );

  // bit order: busy done acc_clr acc_sh max_clr quant_clr quant_start
  assign outv = {busy, done, acc_clr, acc_sh, max_clr, quant_clr, quant_start};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs in cycle k of a job: CLR, cd RUN cycles, QUANT, O OUT cycles, DONE.
  function automatic logic [6:0] model(int k, int cd, int ip, int wp, int op);
    int p, o;
    p = ((ip < 1) ? 1 : ip) * ((wp < 1) ? 1 : wp);
    o = (op < 1) ? 1 : op;
    if (k == 1) return 7'b1010110;
    if (k >= 2 && k <= cd + 1) return (((k - 1) % p) == 0) ? 7'b1001000 : 7'b1000000;
    if (k == cd + 2) return 7'b1000001;
    if (k <= cd + 2 + o) return 7'b1000000;
    if (k == cd + 3 + o) return 7'b1100000;
    return 7'b0000000;
  endfunction

  task automatic run_job(input int cd, input int ip, input int wp, input int op,
                         input int abort_k, input bit noise, input string name);
    int len, o;
    logic [6:0] exp_v;
    o = (op < 1) ? 1 : op;
    len = (abort_k > 0) ? abort_k + 6 : cd + o + 6;
    if (len > 255) len = 255;
    @(negedge clk);
    countdown = 29'(cd); iprecision = 6'(ip); wprecision = 6'(wp); oprecision = 6'(op);
    start = 1'b1; abort = 1'b0;
    @(posedge clk);
    n_done = 0; n_sh = 0;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      obs[k] = outv;
`ifdef MVU_JOB_CTRL_IRQ_EN
      irq_obs[k] = irq;
`endif
      exp_v = (abort_k > 0 && k > abort_k) ? 7'b0000000 : model(k, cd, ip, wp, op);
      total++;
      if (outv !== exp_v) begin
        bad++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, k, outv, exp_v);
      end
      if (outv[5] === 1'b1) n_done++;
      if (outv[3] === 1'b1) n_sh++;
      start = 1'b0;
      abort = (k == abort_k);
      if (noise && k <= cd + 3 + o) begin
        start = 1'($urandom_range(0, 1));
        countdown = 29'($urandom);
        iprecision = 6'($urandom); wprecision = 6'($urandom); oprecision = 6'($urandom);
      end
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; abort = 1'b0;
    countdown = 29'd5; iprecision = 6'd1; wprecision = 6'd1; oprecision = 6'd1;
`ifdef MVU_JOB_CTRL_IRQ_EN
    irq_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    total++;
    if (outv !== 7'b0) begin bad++; $display("FAIL reset_outputs: got %b expected 0000000", outv); end
`ifdef MVU_JOB_CTRL_IRQ_EN
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b expected 0", irq); end
`endif
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (outv !== 7'b0) begin bad++; $display("FAIL idle_after_reset: got %b expected 0000000", outv); end
  endtask

  task automatic test_basic();
    run_job(8, 2, 2, 4, 0, 1'b0, "basic");
    total++; if (obs[1][4] !== 1'b1) begin bad++; $display("FAIL basic_acc_clr_c1: got %b expected 1", obs[1][4]); end
    total++; if (obs[5][3] !== 1'b1) begin bad++; $display("FAIL basic_acc_sh_run4: got %b expected 1", obs[5][3]); end
    total++; if (obs[9][3] !== 1'b1) begin bad++; $display("FAIL basic_acc_sh_run8: got %b expected 1", obs[9][3]); end
    total++; if (obs[10][0] !== 1'b1) begin bad++; $display("FAIL basic_quant_c10: got %b expected 1", obs[10][0]); end
    total++; if (obs[15][5] !== 1'b1) begin bad++; $display("FAIL basic_done_c15: got %b expected 1", obs[15][5]); end
    total++; if (n_sh != 2) begin bad++; $display("FAIL basic_sh_count: got %0d expected 2", n_sh); end
  endtask

  task automatic test_partial();
    run_job(7, 2, 2, $urandom_range(0, 5), 0, 1'b0, "partial");
    total++; if (obs[5][3] !== 1'b1) begin bad++; $display("FAIL partial_sh_run4: got %b expected 1", obs[5][3]); end
    total++; if (n_sh != 1) begin bad++; $display("FAIL partial_sh_count: got %0d expected 1", n_sh); end
  endtask

  task automatic test_zero();
    run_job(0, $urandom_range(0, 7), $urandom_range(0, 7), 0, 0, 1'b0, "zero");
    total++; if (obs[1] !== 7'b1010110) begin bad++; $display("FAIL zero_clr: got %b expected 1010110", obs[1]); end
    total++; if (obs[2] !== 7'b1000001) begin bad++; $display("FAIL zero_quant: got %b expected 1000001", obs[2]); end
    total++; if (obs[3] !== 7'b1000000) begin bad++; $display("FAIL zero_out: got %b expected 1000000", obs[3]); end
    total++; if (obs[4] !== 7'b1100000) begin bad++; $display("FAIL zero_done: got %b expected 1100000", obs[4]); end
    total++; if (n_sh != 0) begin bad++; $display("FAIL zero_sh_count: got %0d expected 0", n_sh); end
  endtask

  task automatic test_abort();
    run_job(100, $urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(0, 6), 4, 1'b0, "abort");
    total++; if (obs[5][6] !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b expected 0", obs[5][6]); end
    total++; if (n_done != 0) begin bad++; $display("FAIL abort_no_done: got %0d expected 0", n_done); end
    run_job(3, 1, 1, 1, 0, 1'b0, "after_abort");
    total++; if (n_done != 1) begin bad++; $display("FAIL after_abort_done: got %0d expected 1", n_done); end
  endtask

  task automatic test_busy_start();
    run_job($urandom_range(10, 40), $urandom_range(1, 3), $urandom_range(1, 3),
            $urandom_range(0, 8), 0, 1'b1, "busy_start");
    total++; if (n_done != 1) begin bad++; $display("FAIL busy_start_done: got %0d expected 1", n_done); end
  endtask

  task automatic test_random();
    int cd, ip, wp, op, p;
    for (int i = 0; i < 8; i++) begin
      cd = $urandom_range(0, 60);
      ip = $urandom_range(0, 7); wp = $urandom_range(0, 7); op = $urandom_range(0, 10);
      p  = ((ip < 1) ? 1 : ip) * ((wp < 1) ? 1 : wp);
      run_job(cd, ip, wp, op, 0, 1'($urandom_range(0, 1)), "random");
      total++; if (n_done != 1) begin bad++; $display("FAIL random_done: got %0d expected 1", n_done); end
      total++; if (n_sh != cd / p) begin bad++; $display("FAIL random_sh_count: got %0d expected %0d", n_sh, cd / p); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    countdown = 29'd50; iprecision = 6'd2; wprecision = 6'd3; oprecision = 6'd2;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_mid_busy_before: got %b expected 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (outv !== 7'b0) begin bad++; $display("FAIL reset_mid_async: got %b expected 0000000", outv); end
    @(negedge clk);
    total++; if (outv !== 7'b0) begin bad++; $display("FAIL reset_mid_held: got %b expected 0000000", outv); end
    rst_n = 1'b1;
    run_job(2, 1, 1, 1, 0, 1'b0, "post_reset");
    total++; if (n_done != 1) begin bad++; $display("FAIL post_reset_done: got %0d expected 1", n_done); end
  endtask

`ifdef MVU_JOB_CTRL_IRQ_EN
  task automatic test_irq();
    irq_clr = 1'b0;
    run_job(2, 1, 1, 0, 0, 1'b0, "irq_job");
    total++; if (irq_obs[5] !== 1'b0) begin bad++; $display("FAIL irq_before_done: got %b expected 0", irq_obs[5]); end
    total++; if (irq_obs[6] !== 1'b1) begin bad++; $display("FAIL irq_at_done: got %b expected 1", irq_obs[6]); end
    total++; if (irq_obs[9] !== 1'b1) begin bad++; $display("FAIL irq_held: got %b expected 1", irq_obs[9]); end
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_cleared: got %b expected 0", irq); end
    irq_clr = 1'b1;
    run_job(1, 1, 1, 1, 0, 1'b0, "irq_coincide");
    total++; if (irq_obs[5] !== 1'b1) begin bad++; $display("FAIL irq_set_wins: got %b expected 1", irq_obs[5]); end
    total++; if (irq_obs[6] !== 1'b0) begin bad++; $display("FAIL irq_clear_after: got %b expected 0", irq_obs[6]); end
    irq_clr = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_zero();
    test_abort();
    test_busy_start();
    test_random();
    test_reset_mid();
`ifdef MVU_JOB_CTRL_IRQ_EN
    test_irq();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
